// File: rtl/di_ni_wb_writer.sv
// di_ni_wb_writer: writes incoming DI packets to BE/TDM NI endpoints through a Wishbone master port.
module di_ni_wb_writer #(
    parameter int NUM_BE_ENDPOINTS = 1,
    parameter int NUM_TDM_ENDPOINTS = 1,
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int ACK_TIMEOUT = 255,
    localparam int SW = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [SW-1:0]             packet_size,
    input  logic [NOC_FLIT_WIDTH-1:0] in_flit_data,
    input  logic                      in_flit_valid,
    input  logic                      in_flit_last,
    output logic                      in_flit_ready,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    output logic [31:0]               wb_adr_o,
    output logic [NOC_FLIT_WIDTH-1:0] wb_dat_o,
    output logic                      wb_stb_o,
    output logic                      wb_cyc_o,
    output logic                      req,
    output logic                      err_pulse,
    output logic [1:0]                err_code,
    output logic [15:0]               drop_count
);
    typedef enum logic [2:0] {IDLE, ENDPOINT, SIZE, WRITE, DRAIN} state_t;
    state_t state_q, state_d;
    logic [15:0] tmo_q, tmo_d, drop_count_q, drop_count_d;
    logic [31:0] adr_q, adr_d;
    logic [1:0]  err_code_q, err_code_d, abort_code;
    logic        err_pulse_q, err_pulse_d;
    logic [14:0] idx;
    logic        cls, hdr_ok, hdr_abort, stb, ack, err, tmo_hit, abort;
    always_comb begin
        idx = in_flit_data[14:0];
        cls = in_flit_data[15];
        hdr_ok = cls ? (int'(idx) < NUM_TDM_ENDPOINTS) : (int'(idx) < NUM_BE_ENDPOINTS);
        stb = (state_q == SIZE) || (state_q == WRITE && in_flit_valid);
        err = stb && wb_err_i;
        ack = stb && wb_ack_i && !wb_err_i;
        tmo_hit = stb && !wb_ack_i && !wb_err_i && tmo_q == 16'(ACK_TIMEOUT - 1);
        hdr_abort = state_q == ENDPOINT && in_flit_valid && (!hdr_ok || in_flit_last);
        abort = hdr_abort || err || tmo_hit;
        abort_code = hdr_abort ? 2'd1 : err ? 2'd2 : 2'd3;
        // the counter holds while WRITE waits for a flit with stb low
        tmo_d = (stb && !wb_ack_i && !wb_err_i) ? tmo_q + 16'd1 : (state_q == WRITE && !stb) ? tmo_q : 16'd0;
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = (in_flit_valid && enable) ? ENDPOINT : IDLE;
            ENDPOINT: state_d = !in_flit_valid ? ENDPOINT : in_flit_last ? IDLE : !hdr_ok ? DRAIN : cls ? WRITE : SIZE;
            SIZE:     state_d = abort ? DRAIN : ack ? WRITE : SIZE;
            WRITE:    state_d = abort ? DRAIN : (ack && in_flit_last) ? IDLE : WRITE;
            DRAIN:    state_d = (in_flit_valid && in_flit_last) ? IDLE : DRAIN;
            default:  state_d = IDLE;
        endcase
        adr_d = (state_q == ENDPOINT && in_flit_valid && !hdr_abort) ?
                {8'h00, cls ? 4'h2 : 4'h1, 7'(idx + 15'd1), 13'h0000} : adr_q;
        err_code_d = abort ? abort_code : err_code_q;
        drop_count_d = drop_count_q + 16'(abort && drop_count_q != 16'hFFFF);
        err_pulse_d = abort;
        in_flit_ready = !rst && (state_q == ENDPOINT ? in_flit_valid : state_q == WRITE ? ack : state_q == DRAIN);
        wb_stb_o = !rst && stb;
        wb_cyc_o = wb_stb_o;
        wb_dat_o = rst ? '0 : state_q == SIZE ? NOC_FLIT_WIDTH'(packet_size) : in_flit_data;
        req = !rst && (state_q == IDLE ? in_flit_valid :
                       state_q == ENDPOINT || state_q == SIZE || (state_q == WRITE && !(ack && in_flit_last)));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q <= '0;
            adr_q <= '0;
            err_code_q <= '0;
            drop_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q <= tmo_d;
            adr_q <= adr_d;
            err_code_q <= err_code_d;
            drop_count_q <= drop_count_d;
            err_pulse_q <= err_pulse_d;
        end
    end
    assign wb_adr_o = adr_q;
    assign err_code = err_code_q;
    assign drop_count = drop_count_q;
    assign err_pulse = err_pulse_q;
endmodule

// File: tb/tb_di_ni_wb_writer.sv
// tb_di_ni_wb_writer: table-driven packets with a WB write scoreboard, plus reset and saturation sequences.
module tb_di_ni_wb_writer;
    localparam int W = 32;
    localparam int SW = 5;
    localparam int NBE = 1;
    localparam int NTDM = 2;
    logic          clk = 1'b0, rst = 1'b1, enable = 1'b1;
    logic [SW-1:0] packet_size = '0;
    logic [W-1:0]  in_flit_data = '0;
    logic          in_flit_valid = 1'b0, in_flit_last = 1'b0;
    logic          in_flit_ready, wb_ack_i, wb_err_i, wb_stb_o, wb_cyc_o, req, err_pulse;
    logic [31:0]   wb_adr_o;
    logic [W-1:0]  wb_dat_o;
    logic [1:0]    err_code;
    logic [15:0]   drop_count;
    int n_checks = 0, n_fail = 0;
    int wr_idx = 0, err_at = -1, stb_cycles = 0, pulses = 0;
    bit no_ack = 1'b0;
    logic [63:0] sb[$];
    logic [1:0]  exp_code = 2'd0;
    logic [15:0] exp_drop = 16'd0;
    typedef struct {
        logic [15:0] hdr;
        int          n;
        int          err_at;
        bit          no_ack;
        logic [1:0]  code;
        logic [31:0] adr;
    } vec_t;
    vec_t vecs[12];
    di_ni_wb_writer #(
        .NUM_BE_ENDPOINTS(NBE), .NUM_TDM_ENDPOINTS(NTDM), .NOC_FLIT_WIDTH(W), .DEPTH(16), .ACK_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .packet_size(packet_size),
        .in_flit_data(in_flit_data), .in_flit_valid(in_flit_valid), .in_flit_last(in_flit_last),
        .in_flit_ready(in_flit_ready), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .req(req), .err_pulse(err_pulse), .err_code(err_code), .drop_count(drop_count)
    );
    always #5 clk = ~clk;
    // zero-wait slave; err is raised on the chosen write index together with ack
    assign wb_ack_i = wb_stb_o && !no_ack;
    assign wb_err_i = wb_stb_o && (wr_idx == err_at);
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step(output bit consumed);
        bit acked;
        logic [63:0] e;
        #1;
        consumed = in_flit_valid && in_flit_ready;
        acked = wb_stb_o && wb_ack_i && !wb_err_i;
        if (wb_stb_o) stb_cycles++;
        if (err_pulse) pulses++;
        if (acked) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_adr", wb_adr_o, e[63:32]);
                chk("wb_dat", wb_dat_o, e[31:0]);
            end
            chk("cyc_eq_stb", 32'(wb_cyc_o), 32'd1);
        end
        @(negedge clk);
        if (acked) wr_idx++;
    endtask
    task automatic send_flit(input logic [W-1:0] d, input bit last);
        bit c = 1'b0;
        in_flit_data = d;
        in_flit_last = last;
        in_flit_valid = 1'b1;
        for (int i = 0; i < 40 && !c; i++) step(c);
        chk("flit_consumed", 32'(c), 32'd1);
        in_flit_valid = 1'b0;
        in_flit_last = 1'b0;
    endtask
    task automatic run_vec(input vec_t v, input int vi);
        bit c;
        bit cls = v.hdr[15];
        int idx = int'(v.hdr[14:0]);
        bit good = (cls ? idx < NTDM : idx < NBE) && v.n > 0;
        int k = 0;
        wr_idx = 0;
        err_at = v.err_at;
        no_ack = v.no_ack;
        stb_cycles = 0;
        pulses = 0;
        packet_size = SW'(v.n);
        if (good && !v.no_ack) begin
            if (!cls) begin
                if (err_at < 0 || k < err_at) sb.push_back({v.adr, 32'(v.n)});
                k++;
            end
            for (int i = 0; i < v.n; i++) begin
                if (err_at < 0 || k < err_at) sb.push_back({v.adr, 32'hD000_0000 | 32'(vi << 8) | 32'(i)});
                k++;
            end
        end
        send_flit(W'(v.hdr), v.n == 0);
        for (int i = 0; i < v.n; i++) send_flit(32'hD000_0000 | 32'(vi << 8) | 32'(i), i == v.n - 1);
        repeat (3) step(c);
        if (v.code != 2'd0) begin
            exp_code = v.code;
            exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
        end
        chk($sformatf("v%0d_err_code", vi), 32'(err_code), 32'(exp_code));
        chk($sformatf("v%0d_drop_count", vi), 32'(drop_count), 32'(exp_drop));
        chk($sformatf("v%0d_pulses", vi), 32'(pulses), 32'(v.code != 2'd0));
        chk($sformatf("v%0d_sb_left", vi), 32'(sb.size()), 32'd0);
        chk($sformatf("v%0d_req_idle", vi), 32'(req), 32'd0);
        if (v.code != 2'd1) chk($sformatf("v%0d_adr", vi), wb_adr_o, v.adr);
        if (v.no_ack) chk($sformatf("v%0d_stb_cycles", vi), 32'(stb_cycles), 32'd4);
        sb.delete();
        err_at = -1;
        no_ack = 1'b0;
    endtask
    initial begin
        bit c;
        vecs[0]  = '{16'h0000, 3, -1, 1'b0, 2'd0, 32'h0010_2000};
        vecs[1]  = '{16'h8000, 2, -1, 1'b0, 2'd0, 32'h0020_2000};
        vecs[2]  = '{16'h8001, 1, -1, 1'b0, 2'd0, 32'h0020_4000};
        vecs[3]  = '{16'h0001, 3, -1, 1'b0, 2'd1, 32'h0};
        vecs[4]  = '{16'h8002, 2, -1, 1'b0, 2'd1, 32'h0};
        vecs[5]  = '{16'h0000, 3,  2, 1'b0, 2'd2, 32'h0010_2000};
        vecs[6]  = '{16'h0000, 2, -1, 1'b0, 2'd0, 32'h0010_2000};
        vecs[7]  = '{16'h0000, 0, -1, 1'b0, 2'd1, 32'h0};
        vecs[8]  = '{16'h8000, 1, -1, 1'b1, 2'd3, 32'h0020_2000};
        vecs[9]  = '{16'h0000, 2,  0, 1'b0, 2'd2, 32'h0010_2000};
        vecs[10] = '{16'h8001, 3, -1, 1'b0, 2'd0, 32'h0020_4000};
        vecs[11] = '{16'h7FFF, 1, -1, 1'b0, 2'd1, 32'h0};
        in_flit_valid = 1'b1;
        in_flit_data = 32'h0000_8000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(in_flit_ready), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_flit_valid = 1'b0;
        step(c);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
        force dut.drop_count_q = 16'hFFFF;
        step(c);
        release dut.drop_count_q;
        step(c);
        chk("sat_preset", 32'(drop_count), 32'hFFFF);
        exp_drop = 16'hFFFF;
        run_vec(vecs[3], 12);
        packet_size = 5'd2;
        send_flit(32'h0000_8000, 1'b0);
        in_flit_data = 32'hBEEF_0001;
        in_flit_last = 1'b1;
        in_flit_valid = 1'b1;
        no_ack = 1'b1;
        step(c);
        step(c);
        pulses = 0;
        rst = 1'b1;
        #1;
        chk("midrst_stb", 32'(wb_stb_o), 32'd0);
        chk("midrst_ready", 32'(in_flit_ready), 32'd0);
        chk("midrst_req", 32'(req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_flit_valid = 1'b0;
        in_flit_last = 1'b0;
        no_ack = 1'b0;
        repeat (3) step(c);
        chk("midrst_pulses", 32'(pulses), 32'd0);
        chk("midrst_drop", 32'(drop_count), 32'd0);
        chk("midrst_err_code", 32'(err_code), 32'd0);
        chk("midrst_adr", wb_adr_o, 32'd0);
        exp_drop = 16'd0;
        exp_code = 2'd0;
        run_vec(vecs[0], 13);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
